hex_frame_handler: RTL and testbench

Parametrised successor to the single-format byte input handler: parses ASCII command frames (ID char, command char, optional hex length, hex data digits) arriving one byte at a time into a command register and a wide data buffer. Sits between the byte receiver (UART/host link) and the command dispatcher. Adds configurable buffer width, explicit-length or terminator-delimited framing, error reporting and a ready/request consumer handshake.

---
 rtl/hex_frame_handler.sv | 167 ++++++++++++++++
 tb/tb_hex_frame_handler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_frame_handler.sv
// ASCII command-frame parser: 'ID cmd [len_hi len_lo] hex-digits [TERM]' arriving one
// byte at a time, decoded into a command register and a wide shift buffer.
module hex_frame_handler #(
  parameter int unsigned BUF_BITS  = 256,
  parameter int unsigned CW        = 16,
  parameter logic [7:0]  ID_CHAR   = 8'h4C,
  parameter int          LEN_MODE  = 0,
  parameter logic [7:0]  TERM_CHAR = 8'h0D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                byte_available,
  input  logic [7:0]          byte_in,
  input  logic                data_request,
  output logic [7:0]          command,
  output logic [CW-1:0]       data_count,
  output logic [BUF_BITS-1:0] buffer,
  output logic                ready,
  output logic                error,
  output logic [1:0]          err_code,
  output logic                overrun,
  output logic [7:0]          debug
);

  localparam int unsigned    CAP   = BUF_BITS / 4;
  localparam logic [CW-1:0]  CAP_C = CW'(CAP);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_LEN_HI = 3'd2,
    S_LEN_LO = 3'd3,
    S_DATA   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // {valid, nibble}; letters of either case share the low nibble offset of 9
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= 8'h30 && b <= 8'h39)
      r = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      r = {1'b1, b[3:0] + 4'd9};
    return r;
  endfunction

  state_t        state;
  logic          avail_q;
  logic [3:0]    len_hi;
  logic [CW-1:0] len_q;

  logic          accept;
  logic [4:0]    dec;
  logic          digit_ok;
  logic [7:0]    len_full;
  logic [CW-1:0] count_nx;

  assign accept   = byte_available & ~avail_q;
  assign dec      = hex_decode(byte_in);
  // the frame-start character is never a data digit, even if it happens to be hex
  assign digit_ok = dec[4] & (byte_in != ID_CHAR);
  assign len_full = {len_hi, dec[3:0]};
  assign count_nx = data_count + CW'(1);
  assign debug    = {5'b0, state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      avail_q    <= 1'b0;
      len_hi     <= '0;
      len_q      <= '0;
      command    <= '0;
      data_count <= '0;
      buffer     <= '0;
      ready      <= 1'b0;
      error      <= 1'b0;
      err_code   <= '0;
      overrun    <= 1'b0;
    end else begin
      avail_q <= byte_available;
      case (state)
        S_IDLE: begin
          if (accept && byte_in == ID_CHAR) begin
            state      <= S_CMD;
            buffer     <= '0;
            data_count <= '0;
            error      <= 1'b0;
            err_code   <= '0;
            overrun    <= 1'b0;
          end
        end
        S_CMD: begin
          if (accept) begin
            command <= byte_in;
            state   <= (LEN_MODE != 0) ? S_LEN_HI : S_DATA;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            if (digit_ok) begin
              len_hi <= dec[3:0];
              state  <= S_LEN_LO;
            end else begin
              error    <= 1'b1;
              err_code <= 2'd1;
              state    <= S_IDLE;
            end
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            if (!digit_ok) begin
              error    <= 1'b1;
              err_code <= 2'd1;
              state    <= S_IDLE;
            end else if ({24'd0, len_full} > CAP) begin
              error    <= 1'b1;
              err_code <= 2'd3;
              state    <= S_IDLE;
            end else if (len_full == 8'd0) begin
              ready <= 1'b1;
              state <= S_DONE;
            end else begin
              len_q <= CW'(len_full);
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            if (LEN_MODE == 0 && byte_in == TERM_CHAR) begin
              ready <= 1'b1;
              state <= S_DONE;
            end else if (!digit_ok) begin
              error    <= 1'b1;
              err_code <= 2'd1;
              state    <= S_IDLE;
            end else if (LEN_MODE == 0 && data_count == CAP_C) begin
              // overflow keeps the partial buffer visible for diagnosis
              error    <= 1'b1;
              err_code <= 2'd2;
              state    <= S_IDLE;
            end else begin
              buffer     <= {buffer[BUF_BITS-5:0], dec[3:0]};
              data_count <= count_nx;
              if (LEN_MODE != 0 && count_nx == len_q) begin
                ready <= 1'b1;
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (accept)
            overrun <= 1'b1;
          if (data_request) begin
            ready <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_frame_handler.sv
// Bench for hex_frame_handler: two instances (terminator and explicit-length framing),
// directed frames plus random frames checked by a queue-based scoreboard.
module tb_hex_frame_handler;

  localparam int CAP = 64;
  localparam logic [7:0] TERM = 8'h0D;
  localparam logic [7:0] IDC  = 8'h4C;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;    // 0 no outcome, 1 ready, 2 error
    logic [7:0]  cmd;
    int          count;
    logic [255:0] buffer;
    int          code;
    int          nbytes;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic av0 = 1'b0, av1 = 1'b0, req0 = 1'b0, req1 = 1'b0;

  logic [7:0] cmd0, cmd1, dbg0, dbg1;
  logic [15:0] cnt0, cnt1;
  logic [255:0] buf0, buf1;
  logic rdy0, rdy1, err0, err1, ovr0, ovr1;
  logic [1:0] code0, code1;

  int vectors = 0;
  int miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] bad [10] = '{8'h47, 8'h7A, 8'h20, 8'h4C, 8'h00, 8'h2F, 8'h3A, 8'h40, 8'h60, 8'h67};

  always #4 clk = ~clk;

  hex_frame_handler #(.BUF_BITS(256), .CW(16), .ID_CHAR(IDC), .LEN_MODE(0), .TERM_CHAR(TERM)) d0 (
    .clk(clk), .rst_n(rst_n), .byte_available(av0), .byte_in(byte_in), .data_request(req0),
    .command(cmd0), .data_count(cnt0), .buffer(buf0), .ready(rdy0), .error(err0),
    .err_code(code0), .overrun(ovr0), .debug(dbg0));

  hex_frame_handler #(.BUF_BITS(256), .CW(16), .ID_CHAR(IDC), .LEN_MODE(1), .TERM_CHAR(TERM)) d1 (
    .clk(clk), .rst_n(rst_n), .byte_available(av1), .byte_in(byte_in), .data_request(req1),
    .command(cmd1), .data_count(cnt1), .buffer(buf1), .ready(rdy1), .error(err1),
    .err_code(code1), .overrun(ovr1), .debug(dbg1));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int hexval(input logic [7:0] b);
    string digs;
    logic [7:0] c;
    digs = "0123456789abcdef";
    c = (b >= 8'h41 && b <= 8'h46) ? b + 8'd32 : b;
    for (int k = 0; k < 16; k++)
      if (c == digs[k]) return k;
    return -1;
  endfunction

  function automatic logic [7:0] hexch(input int v, input bit lower);
    string up, lo;
    up = "0123456789ABCDEF";
    lo = "0123456789abcdef";
    return lower ? lo[v] : up[v];
  endfunction

  function automatic exp_t model(input bq_t f, input bit lm);
    exp_t e;
    int v, len;
    e.kind = 0; e.cmd = f[1]; e.count = 0; e.buffer = '0; e.code = 0; e.nbytes = f.size();
    if (lm) begin
      v = hexval(f[2]);
      if (v < 0) begin e.kind = 2; e.code = 1; e.nbytes = 3; return e; end
      len = v * 16;
      v = hexval(f[3]);
      if (v < 0) begin e.kind = 2; e.code = 1; e.nbytes = 4; return e; end
      len += v;
      if (len > CAP) begin e.kind = 2; e.code = 3; e.nbytes = 4; return e; end
      if (len == 0) begin e.kind = 1; e.nbytes = 4; return e; end
      for (int i = 4; i < f.size(); i++) begin
        v = hexval(f[i]);
        if (v < 0) begin e.kind = 2; e.code = 1; e.nbytes = i + 1; return e; end
        e.count++;
        e.buffer = (e.buffer << 4) | 256'(v);
        if (e.count == len) begin e.kind = 1; e.nbytes = i + 1; return e; end
      end
    end else begin
      for (int i = 2; i < f.size(); i++) begin
        if (f[i] == TERM) begin e.kind = 1; e.nbytes = i + 1; return e; end
        v = hexval(f[i]);
        if (v < 0) begin e.kind = 2; e.code = 1; e.nbytes = i + 1; return e; end
        if (e.count == CAP) begin e.kind = 2; e.code = 2; e.nbytes = i + 1; return e; end
        e.count++;
        e.buffer = (e.buffer << 4) | 256'(v);
      end
    end
    return e;
  endfunction

  function automatic bq_t gen_frame(input bit lm);
    bq_t f;
    int r, n;
    f.push_back(IDC);
    f.push_back(8'($urandom));
    r = $urandom_range(0, 9);
    if (lm) begin
      if (r == 0) n = 0;
      else if (r == 1) n = $urandom_range(65, 255);
      else if (r == 2) n = 64;
      else n = $urandom_range(1, 24);
      f.push_back(hexch(n / 16, 1'($urandom)));
      f.push_back(hexch(n % 16, 1'($urandom)));
      if (n > CAP) n = 4;
    end else begin
      if (r == 0) n = 0;
      else if (r == 1) n = 65;
      else if (r == 2) n = 64;
      else n = $urandom_range(1, 24);
    end
    for (int j = 0; j < n; j++) f.push_back(hexch($urandom_range(0, 15), 1'($urandom)));
    if (!lm) f.push_back(TERM);
    if ($urandom_range(0, 4) == 0) f[$urandom_range(2, f.size() - 1)] = bad[$urandom_range(0, 9)];
    return f;
  endfunction

  // ---------------- scoreboard monitors ----------------
  task automatic check_outcome(input string tag, input exp_t e, input bit err_evt,
                               input logic [7:0] cmd, input logic [15:0] cnt, input logic [255:0] bf,
                               input logic [1:0] code, input logic [7:0] dbg);
    chk({tag, "_kind"}, 256'(err_evt ? 2 : 1), 256'(e.kind));
    chk({tag, "_cmd"}, 256'(cmd), 256'(e.cmd));
    if (e.kind == 1) begin
      chk({tag, "_count"}, 256'(cnt), 256'(e.count));
      chk({tag, "_buffer"}, bf, e.buffer);
      chk({tag, "_state_done"}, 256'(dbg), 256'(5));
    end else begin
      chk({tag, "_err_code"}, 256'(code), 256'(e.code));
      chk({tag, "_state_idle"}, 256'(dbg), 256'(0));
    end
  endtask

  logic rdy0_q = 1'b0, err0_q = 1'b0, rdy1_q = 1'b0, err1_q = 1'b0;
  exp_t m0, m1;

  always @(negedge clk) begin
    if ((rdy0 && !rdy0_q) || (err0 && !err0_q)) begin
      if (q0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL d0_unexpected: ready=%0b error=%0b required no event", rdy0, err0);
      end else begin
        m0 = q0.pop_front();
        check_outcome("d0", m0, err0 && !err0_q, cmd0, cnt0, buf0, code0, dbg0);
      end
    end
    rdy0_q <= rdy0; err0_q <= err0;
  end

  always @(negedge clk) begin
    if ((rdy1 && !rdy1_q) || (err1 && !err1_q)) begin
      if (q1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL d1_unexpected: ready=%0b error=%0b required no event", rdy1, err1);
      end else begin
        m1 = q1.pop_front();
        check_outcome("d1", m1, err1 && !err1_q, cmd1, cnt1, buf1, code1, dbg1);
      end
    end
    rdy1_q <= rdy1; err1_q <= err1;
  end

  // ---------------- stimulus ----------------
  // hold: 0 = strobe held 14 time units, N>0 = held N clock cycles
  task automatic send_byte(input int d, input logic [7:0] b, input int hold);
    @(negedge clk);
    byte_in = b;
    if (d == 0) av0 = 1'b1; else av1 = 1'b1;
    if (hold == 0) #14;
    else repeat (hold) @(negedge clk);
    av0 = 1'b0; av1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_frame(input int d);
    @(negedge clk);
    if (d == 0) req0 = 1'b1; else req1 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    chk("ready_release", 256'(d == 0 ? rdy0 : rdy1), 256'(0));
  endtask

  task automatic send_frame(input int d, input bq_t f, input bit auto_req, input int hold, output exp_t e);
    e = model(f, d == 1);
    if (e.kind != 0) begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    for (int i = 0; i < e.nbytes; i++)
      send_byte(d, f[i], hold < 0 ? int'($urandom_range(0, 3)) : hold);
    if (e.kind == 1 && auto_req) release_frame(d);
  endtask

  bq_t f;
  exp_t e;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_command", 256'(cmd0), 256'(0));
    chk("rst_count", 256'(cnt0), 256'(0));
    chk("rst_buffer", buf0, 256'(0));
    chk("rst_flags", 256'({rdy0, err0, code0, ovr0, rdy1, err1, ovr1}), 256'(0));
    chk("rst_debug", 256'(dbg0), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // terminator framing, strobe held across two clock samples per byte
    f = '{IDC, 8'h31};
    for (int k = 0; k < 16; k++) f.push_back(hexch(k, 1'b0));
    f.push_back(TERM);
    send_frame(0, f, 1'b0, 0, e);
    chk("plan_ready", 256'(rdy0), 256'(1));
    chk("plan_count", 256'(cnt0), 256'(16));
    chk("plan_buffer", buf0, 256'h0123456789ABCDEF);
    release_frame(0);

    // explicit length, then the overrun cases while ready
    f = '{IDC, 8'h32, 8'h30, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64};
    send_frame(1, f, 1'b0, 1, e);
    chk("len4_buffer", buf1, 256'hABCD);
    chk("len4_count", 256'(cnt1), 256'(4));
    send_byte(1, 8'h35, 1);
    chk("ovr_flag", 256'(ovr1), 256'(1));
    chk("ovr_buffer", buf1, 256'hABCD);
    chk("ovr_ready_held", 256'(rdy1), 256'(1));
    @(negedge clk);
    byte_in = 8'h37; av1 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    av1 = 1'b0; req1 = 1'b0;
    chk("same_cycle_ready", 256'(rdy1), 256'(0));
    chk("same_cycle_ovr", 256'(ovr1), 256'(1));
    chk("same_cycle_idle", 256'(dbg1), 256'(0));
    @(negedge clk);
    f = '{IDC, 8'h32, 8'h30, 8'h30};
    send_frame(1, f, 1'b0, 1, e);
    chk("len0_ready", 256'(rdy1), 256'(1));
    chk("len0_count", 256'(cnt1), 256'(0));
    chk("len0_ovr_cleared", 256'(ovr1), 256'(0));
    release_frame(1);

    // error frames
    f = '{IDC, 8'h31, 8'h33, 8'h47};
    send_frame(0, f, 1'b1, 1, e);
    chk("nonhex_error", 256'({err0, code0}), 256'({1'b1, 2'd1}));
    f = '{IDC, 8'h31, 8'h46, 8'h46};
    send_frame(1, f, 1'b1, 1, e);
    chk("toolong_code", 256'(code1), 256'(3));
    f = '{IDC, 8'h31};
    for (int k = 0; k < 65; k++) f.push_back(hexch(k % 16, 1'b0));
    send_frame(0, f, 1'b1, 1, e);
    chk("overflow_code", 256'(code0), 256'(2));
    chk("overflow_count", 256'(cnt0), 256'(64));
    f = '{IDC, 8'h35, 8'h41, TERM};
    e = model(f, 1'b0);
    q0.push_back(e);
    send_byte(0, f[0], 1);
    chk("restart_clears_error", 256'({err0, code0}), 256'(0));
    for (int i = 1; i < 4; i++) send_byte(0, f[i], 1);
    release_frame(0);

    // asynchronous reset mid-frame
    send_byte(0, IDC, 1);
    send_byte(0, 8'h31, 1);
    send_byte(0, 8'h37, 1);
    chk("partial_count", 256'(cnt0), 256'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 256'({cmd0, cnt0, rdy0, err0, code0, ovr0, dbg0}), 256'(0));
    chk("async_rst_buffer", buf0, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    f = '{IDC, 8'h39, 8'h66, 8'h30, 8'h45, TERM};
    send_frame(0, f, 1'b1, -1, e);

    // random frames on both framing modes
    for (int n = 0; n < 30; n++) begin
      send_frame(0, gen_frame(1'b0), 1'b1, -1, e);
      send_frame(1, gen_frame(1'b1), 1'b1, -1, e);
    end

    repeat (4) @(negedge clk);
    chk("pending_d0", 256'(q0.size()), 256'(0));
    chk("pending_d1", 256'(q1.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
